// File: rtl/shift_reg_seq_univ_if.sv
// Command/status bundle for the universal shift register: the controller drives the
// command side, and the register returns its contents and handshake status.
interface shift_reg_seq_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             start;
  logic [2:0]       op;
  logic [CNTW-1:0]  amt;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, d, sin,
    input  q, sout, busy, done
  );

  modport slave (
    input  start, op, amt, d, sin,
    output q, sout, busy, done
  );
endinterface

// File: rtl/shift_reg_seq_univ.sv
// WIDTH-bit universal register with a one-bit-per-clock shift sequencer and async clear.
// A command is accepted only in IDLE; a shift of n takes n+1 busy cycles, and LOAD or n=0 takes 1.
module shift_reg_seq_univ #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_reg_seq_univ_if.slave   bus
);
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHL  = 3'd1;
  localparam logic [2:0] OP_SHR  = 3'd2;
  localparam logic [2:0] OP_SAR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_SLI  = 3'd6;
  localparam logic [2:0] OP_SRI  = 3'd7;
  localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [CNTW-1:0]  amt_eff;
  logic [WIDTH-1:0] shift_q;
  logic             shift_out;

  // Amounts beyond the register width are clamped, so counting never exceeds WIDTH shifts.
  assign amt_eff = (bus.amt > WIDTH_C) ? WIDTH_C : bus.amt;

  always_comb begin
    shift_q   = q_q;
    shift_out = sout_q;
    case (op_q)
      OP_SHL: begin shift_q = {q_q[WIDTH-2:0], 1'b0};         shift_out = q_q[WIDTH-1]; end
      OP_SHR: begin shift_q = {1'b0, q_q[WIDTH-1:1]};         shift_out = q_q[0];       end
      OP_SAR: begin shift_q = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; shift_out = q_q[0];       end
      OP_ROL: begin shift_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; shift_out = q_q[WIDTH-1]; end
      OP_ROR: begin shift_q = {q_q[0], q_q[WIDTH-1:1]};       shift_out = q_q[0];       end
      OP_SLI: begin shift_q = {q_q[WIDTH-2:0], bus.sin};      shift_out = q_q[WIDTH-1]; end
      OP_SRI: begin shift_q = {bus.sin, q_q[WIDTH-1:1]};      shift_out = q_q[0];       end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          if (bus.op == OP_LOAD) begin
            q_d     = bus.d;
            state_d = DONE;
          end else if (amt_eff == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = amt_eff;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        q_d    = shift_q;
        sout_d = shift_out;
        cnt_d  = cnt_q - ONE_C;
        if (cnt_q == ONE_C) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.sout = sout_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
endmodule

// File: doc/shift_reg_seq_univ.md
Name: shift_reg_seq_univ

Overview:
Parametrised successor to the single-bit async-clear D flip-flop: a WIDTH-bit universal register with asynchronous clear and a built-in shift sequencer.
- One start command loads the register or shifts it by a programmed amount, one bit per clock.
- Modes: logical shift, arithmetic shift, rotate, and serial insert.
- Reports busy/done for a controlling FSM in the lab datapath exercises.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNTW, 4, width of shift-amount input and internal counter; must satisfy 2**CNTW > WIDTH

Ports:
clk    input   1      clock; all state updates on rising edge
reset  input   1      asynchronous, active-high clear
start  input   1      command strobe; sampled only in IDLE
op     input   3      operation select, latched with start
amt    input   CNTW   shift amount, latched with start
d      input   WIDTH  parallel load data (op LOAD)
sin    input   1      serial input bit (ops SLI/SRI), sampled on every shift edge
q      output  WIDTH  register contents
sout   output  1      last bit shifted out
busy   output  1      high whenever state != IDLE
done   output  1      one-cycle pulse, high exactly in state DONE

Behaviour:
- Reset (async, any time, including mid-operation):
  - q=0, sout=0, state=IDLE, busy=0, done=0, counter=0.
  - An aborted operation never produces done.
- op encoding:
  - 0 LOAD: q<=d
  - 1 SHL: logical left, zero in
  - 2 SHR: logical right, zero in
  - 3 SAR: arithmetic right, MSB replicated
  - 4 ROL: rotate left
  - 5 ROR: rotate right
  - 6 SLI: left, LSB<=sin
  - 7 SRI: right, MSB<=sin
- States: IDLE, RUN, DONE.
- IDLE, edge with start=1: latch op; latch amt_eff = min(amt, WIDTH).
  - op=LOAD: q<=d; sout unchanged; next state DONE.
  - op!=LOAD and amt_eff=0: q, sout unchanged; next state DONE.
  - Otherwise: counter<=amt_eff; next state RUN; q not yet modified.
- RUN, each edge:
  - Perform exactly one 1-bit operation per latched op.
  - sout<=bit leaving the register: MSB for left ops, LSB for right ops. For rotates this is the wrapped bit.
  - counter<=counter-1; if counter==1, next state DONE.
- DONE: done=1 for one cycle; next edge returns to IDLE.
- start in RUN or DONE is ignored entirely (no queuing). A new command can be accepted on the edge that leaves DONE only if presented in the following IDLE cycle.
- Latency:
  - Shift of n>0: start edge E0, shifts on E1..En, done high during the cycle after En, busy high from after E0 through the DONE cycle, i.e. n+1 cycles.
  - LOAD or n=0: done in the cycle after E0, busy high 1 cycle.
- d, op and amt may change after the start edge without effect. sin is live and is sampled at each shift edge.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
- Reset then LOAD: reset=1 for 4 units → q=0x00, sout=0, busy=0. Release, start op=0 d=0xA5 → q=0xA5 after E0, done=1 for exactly one cycle, busy=1 that cycle only.
- SHL by 3 from 0xA5 → q sequence 0x4A, 0x94, 0x28 on E1..E3; sout=1 after E3; done pulses the cycle after E3; busy high 4 cycles.
- SAR by 2 from 0x85 → 0xC2, then 0xE1; sout=0. SRI by 2 from 0x00 with sin=1,0 on successive shift edges → 0x80, then 0x40.
- Clamp and rotate: ROR with amt=12 from 0x3C → 8 shifts, q=0x3C at end, sout=0, busy high 9 cycles.
- Zero amount and start during busy: SHL amt=0 → q unchanged, done the next cycle. ROL amt=4 from 0x81 with start pulsed again mid-RUN (op=LOAD d=0xFF) → second start ignored, final q=0x18, single done pulse.
- Reset mid-run: SHR amt=5 from 0xFF, assert reset between E2 and E3 → q immediately 0x00, busy=0, sout=0, no done pulse. After release, the next LOAD works normally.
